col_uram_loader: RTL and testbench

COL_URAM_LOADER -- requirements
Module: col_uram_loader

---
 rtl/col_uram_loader.sv | 145 ++++++++++++++
 tb/tb_col_uram_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/col_uram_loader.sv
// col_uram_loader: streams transposed matrix B from AXI-Stream into a bank of
// URAMs, 16 lanes per set, one 64-bit word per cycle, registered write port.
// Optional macro COL_URAM_LOADER_TLAST_CHK_EN adds a sticky err_tlast output
// flagging a misplaced or missing s_axis_tlast.
module col_uram_loader #(
  parameter int unsigned URAM_ADDR_WIDTH = 12,
  parameter int unsigned NUM_URAM        = 64,
  parameter int unsigned NUM_ADDR        = 4096
) (
`ifdef COL_URAM_LOADER_TLAST_CHK_EN
  output logic                       err_tlast,
`endif
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [63:0]                s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [NUM_URAM-1:0]        uram_ena,
  output logic [NUM_URAM-1:0]        uram_wea,
  output logic [URAM_ADDR_WIDTH-1:0] uram_addra,
  output logic [63:0]                uram_dina,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned LANES   = 16;
  localparam int unsigned LANE_W  = 4;
  localparam int unsigned NUM_SET = NUM_URAM / LANES;
  localparam int unsigned SET_W   = (NUM_SET > 1) ? $clog2(NUM_SET) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                     state_q, state_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [URAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SET_W-1:0]           set_q, set_d;
  logic [NUM_URAM-1:0]        ena_q, ena_d;
  logic [URAM_ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [63:0]                dina_q, dina_d;
  logic                       lane_end, addr_end, is_last;

  assign lane_end = (lane_q == LANE_W'(LANES - 1));
  assign addr_end = (addr_q == URAM_ADDR_WIDTH'(NUM_ADDR - 1));
  assign is_last  = lane_end && addr_end && (set_q == SET_W'(NUM_SET - 1));

  // Next-state, counter walk and registered write-port payload.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    set_d   = set_q;
    ena_d   = '0;
    addra_d = addra_q;
    dina_d  = dina_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          lane_d  = '0;
          addr_d  = '0;
          set_d   = '0;
        end
      end
      LOAD: begin
        if (s_axis_tvalid) begin
          ena_d   = NUM_URAM'(1) << {set_q, lane_q};
          addra_d = addr_q;
          dina_d  = s_axis_tdata;
          if (is_last) begin
            state_d = DONE;
          end else if (lane_end) begin
            lane_d = '0;
            if (addr_end) begin
              addr_d = '0;
              set_d  = set_q + SET_W'(1);
            end else begin
              addr_d = addr_q + URAM_ADDR_WIDTH'(1);
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and write port; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      addr_q  <= '0;
      set_q   <= '0;
      ena_q   <= '0;
      addra_q <= '0;
      dina_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      set_q   <= set_d;
      ena_q   <= ena_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
    end
  end

  assign s_axis_tready = (state_q == LOAD);
  assign busy          = (state_q == LOAD);
  assign done          = (state_q == DONE);
  assign uram_ena      = ena_q;
  assign uram_wea      = ena_q;
  assign uram_addra    = addra_q;
  assign uram_dina     = dina_q;

`ifdef COL_URAM_LOADER_TLAST_CHK_EN
  logic err_q, err_d;

  // Sticky flag: tlast must coincide exactly with the final word; start clears.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) begin
      err_d = 1'b0;
    end else if (state_q == LOAD && s_axis_tvalid && (s_axis_tlast != is_last)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_tlast = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

endmodule

// File: tb/tb_col_uram_loader.sv
// Bench for col_uram_loader: random stimulus against a word-index model.
module tb_col_uram_loader;

  localparam int AW    = 12;
  localparam int NU    = 64;
  localparam int NA    = 4;
  localparam int TOTAL = NU * NA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [NU-1:0] uram_ena, uram_wea;
  logic [AW-1:0] uram_addra;
  logic [63:0]   uram_dina;
  logic          busy, done;
`ifdef COL_URAM_LOADER_TLAST_CHK_EN
  logic          err_tlast;
`endif

  col_uram_loader #(.URAM_ADDR_WIDTH(AW), .NUM_URAM(NU), .NUM_ADDR(NA)) dut (
`ifdef COL_URAM_LOADER_TLAST_CHK_EN
    .err_tlast(err_tlast),
`endif
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .uram_ena(uram_ena), .uram_wea(uram_wea), .uram_addra(uram_addra),
    .uram_dina(uram_dina), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word k lands in URAM (set*16 + lane) at address (k/16) mod NUM_ADDR.
  function automatic int uram_of(input int k);
    return (k / (16 * NA)) * 16 + (k % 16);
  endfunction
  function automatic int addr_of(input int k);
    return (k / 16) % NA;
  endfunction

  // Model: a load is "word counter k runs 0..TOTAL-1", writes show one cycle later.
  bit            m_load, m_done, e_err;
  int            m_k;
  logic [NU-1:0] e_ena;
  logic [AW-1:0] e_addr;
  logic [63:0]   e_din;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 0; m_done <= 0; m_k <= 0; e_err <= 0;
      e_ena <= '0; e_addr <= '0; e_din <= '0;
    end else begin
      e_ena <= '0;
      if (m_done) begin
        m_done <= 0;
      end else if (m_load) begin
        if (s_axis_tvalid) begin
          e_ena  <= NU'(1) << uram_of(m_k);
          e_addr <= AW'(addr_of(m_k));
          e_din  <= s_axis_tdata;
          if (s_axis_tlast != (m_k == TOTAL - 1)) e_err <= 1;
          if (m_k == TOTAL - 1) begin
            m_load <= 0;
            m_done <= 1;
          end
          m_k <= m_k + 1;
        end
      end else if (start) begin
        m_load <= 1;
        m_k    <= 0;
        e_err  <= 0;
      end
    end
  end

  // Per-cycle compare plus a log of every write the DUT issues.
  int wr_cnt = 0;
  int done_cnt = 0;
  int log_idx [4096];
  int log_addr[4096];
  logic [63:0] log_data[4096];

  always @(negedge clk) begin
    chk("tready", 64'(s_axis_tready), 64'(m_load));
    chk("busy", 64'(busy), 64'(m_load));
    chk("done", 64'(done), 64'(m_done));
    chk("ena", 64'(uram_ena), 64'(e_ena));
    chk("wea", 64'(uram_wea), 64'(e_ena));
    chk("addra", 64'(uram_addra), 64'(e_addr));
    chk("dina", uram_dina, e_din);
`ifdef COL_URAM_LOADER_TLAST_CHK_EN
    chk("err_tlast", 64'(err_tlast), 64'(e_err));
`endif
    if (done === 1'b1) done_cnt++;
    if (uram_ena != '0 && wr_cnt < 4096) begin
      for (int i = 0; i < NU; i++) if (uram_ena[i]) log_idx[wr_cnt] = i;
      log_addr[wr_cnt] = int'(uram_addra);
      log_data[wr_cnt] = uram_dina;
      wr_cnt++;
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid.
  task automatic run_load(input int mode, input bit data_is_k, input int bad_k,
                          input int start_k, input int abort_k);
    int n = 0;
    int cyc = 0;
    bit v;
    while (n < TOTAL && cyc < 5000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      s_axis_tvalid = v;
      s_axis_tdata  = data_is_k ? 64'(n) : {$urandom, $urandom};
      s_axis_tlast  = v && ((n == TOTAL - 1) || (n == bad_k));
      start         = v && (n == start_k);
      @(negedge clk);
      cyc++;
      if (v) n++;
      if (abort_k >= 0 && n == abort_k + 1) begin
        #1 rst_n = 1'b0;
        #1;
        chk("ena_at_reset", 64'(uram_ena), 64'd0);
        chk("busy_at_reset", 64'(busy), 64'd0);
        break;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; start = 1'b0;
    if (cyc >= 5000) chk("load_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic finish_load(input string name, input int base, input int d0);
    repeat (3) @(negedge clk);
    chk({name, "_writes"}, 64'(wr_cnt - base), 64'(TOTAL));
    chk({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int base, d0;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, d0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_ena", 64'(uram_ena), 64'd0);
    chk("rst_addra", 64'(uram_addra), 64'd0);
    chk("rst_dina", uram_dina, 64'd0);
    rst_n = 1'b1;

    chk("model_map17_uram", 64'(uram_of(17)), 64'd1);
    chk("model_map17_addr", 64'(addr_of(17)), 64'd1);
    chk("model_map64_uram", 64'(uram_of(64)), 64'd16);
    chk("model_map255_uram", 64'(uram_of(255)), 64'd63);
    chk("model_map255_addr", 64'(addr_of(255)), 64'd3);

    // Back-to-back load with data = k, pinned at known words.
    base = wr_cnt; d0 = done_cnt;
    do_start();
    run_load(0, 1'b1, -1, -1, -1);
    finish_load("b2b", base, d0);
    chk("w0_uram", 64'(log_idx[base]), 64'd0);
    chk("w0_addr", 64'(log_addr[base]), 64'd0);
    chk("w17_uram", 64'(log_idx[base + 17]), 64'd1);
    chk("w17_addr", 64'(log_addr[base + 17]), 64'd1);
    chk("w17_data", log_data[base + 17], 64'd17);
    chk("w64_uram", 64'(log_idx[base + 64]), 64'd16);
    chk("w64_addr", 64'(log_addr[base + 64]), 64'd0);
    chk("w255_uram", 64'(log_idx[base + 255]), 64'd63);
    chk("w255_addr", 64'(log_addr[base + 255]), 64'd3);
    chk("w255_data", log_data[base + 255], 64'd255);

    // Valid in IDLE must not produce writes.
    base = wr_cnt;
    s_axis_tvalid = 1'b1;
    repeat (5) @(negedge clk);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("idle_no_write", 64'(wr_cnt - base), 64'd0);

    // Alternating valid.
    base = wr_cnt; d0 = done_cnt;
    do_start();
    run_load(1, 1'b0, -1, -1, -1);
    finish_load("toggle", base, d0);

    // Random valid with a stray start at word 50.
    base = wr_cnt; d0 = done_cnt;
    do_start();
    run_load(2, 1'b0, -1, 50, -1);
    finish_load("start_in_load", base, d0);
    chk("w50_uram", 64'(log_idx[base + 50]), 64'(uram_of(50)));

    // Reset after word 100, then a fresh load.
    base = wr_cnt;
    do_start();
    run_load(2, 1'b0, -1, -1, 100);
    repeat (3) @(negedge clk);
    chk("abort_writes", 64'(wr_cnt - base), 64'd101);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_more", 64'(wr_cnt - base), 64'd101);
    base = wr_cnt; d0 = done_cnt;
    do_start();
    run_load(0, 1'b0, -1, -1, -1);
    finish_load("after_abort", base, d0);
    chk("reload_w0_uram", 64'(log_idx[base]), 64'd0);
    chk("reload_w0_addr", 64'(log_addr[base]), 64'd0);

    // Misplaced tlast on word 10, then a clean load.
    base = wr_cnt; d0 = done_cnt;
    do_start();
    run_load(2, 1'b0, 10, -1, -1);
    finish_load("bad_tlast", base, d0);
`ifdef COL_URAM_LOADER_TLAST_CHK_EN
    chk("err_set", 64'(err_tlast), 64'd1);
`endif
    base = wr_cnt; d0 = done_cnt;
    do_start();
`ifdef COL_URAM_LOADER_TLAST_CHK_EN
    chk("err_cleared", 64'(err_tlast), 64'd0);
`endif
    run_load(0, 1'b0, -1, -1, -1);
    finish_load("good_tlast", base, d0);
`ifdef COL_URAM_LOADER_TLAST_CHK_EN
    chk("err_stays_clear", 64'(err_tlast), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
